hash_msg_loader: RTL

Input-side message assembler for the Romulus-H hash datapath. Accepts the message as a stream of 32-bit words over a valid/ready handshake and packs eight words into a 256-bit message block for the compression function. Applies Romulus-H byte padding to the final block and flags it, so the hash controller can choose the domain constant. Sits upstream of the cipher core: it fills what `hash_feedfwd` later chains.

---
 rtl/romulush_pkg.sv | 19 +
 rtl/hash_msg_loader_pad.sv | 23 ++
 rtl/hash_msg_loader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/romulush_pkg.sv
// Shared widths and state encoding for the Romulus-H message loader.
// Word/block geometry is fixed here; nothing is parameterised per instance.
package romulush_pkg;

  localparam int WORD_W = 32;
  localparam int BLK_W  = 256;
  localparam int WORDS  = 8;
  localparam int IDX_W  = 3;

  typedef enum logic {
    FILL,
    HOLD
  } state_t;

  function automatic int slot_hi(input int s);
    return BLK_W - 1 - WORD_W * s;
  endfunction

endpackage

// File: rtl/hash_msg_loader_pad.sv
// Byte mask for one message slot, optionally stamping the pad length
// into byte 3 when the slot is the last one of the block.
module hash_pad_word
  import romulush_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [2:0]        i_bytes,
  input  logic              i_is_slot7,
  input  logic [7:0]        i_pad_len,
  output logic [WORD_W-1:0] o_word
);

  always_comb begin
    o_word = i_word;
    for (int k = 0; k < 4; k++) begin
      if (k >= int'(i_bytes))
        o_word[WORD_W-1-8*k -: 8] = '0;
    end
    if (i_is_slot7)
      o_word[7:0] = i_pad_len;
  end

endmodule

// File: rtl/hash_msg_loader.sv
// Packs 32-bit message words into 256-bit padded Romulus-H blocks.
// HASH_LOADER_SKID_EN adds a second fill buffer so filling overlaps HOLD.
module hash_msg_loader
  import romulush_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] di,
  input  logic              di_valid,
  output logic              di_ready,
  input  logic              di_last,
  input  logic [2:0]        di_bytes,
  output logic [BLK_W-1:0]  mo,
  output logic              mo_valid,
  input  logic              mo_ready,
  output logic              mo_last,
  output logic              mo_padded
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [BLK_W-1:0]   r_fill;
  logic [BLK_W-1:0]   r_mo;
  logic               r_mo_last;
  logic               r_mo_pad;
`ifdef HASH_LOADER_SKID_EN
  logic               r_fc;
  logic               r_fl;
  logic               r_fp;
`endif

  logic               w_held;
  logic               w_acc;
  logic               w_wr;
  logic               w_close;
  logic               w_xfer;
  logic [5:0]         w_n;
  logic               w_pad;
  logic [WORD_W-1:0]  w_word;
  logic [WORD_W-1:0]  w_tail;
  logic [BLK_W-1:0]   w_next;

  assign w_held = (r_state == HOLD);
`ifdef HASH_LOADER_SKID_EN
  assign di_ready = !(w_held && r_fc);
`else
  assign di_ready = !w_held;
`endif

  assign w_acc   = di_valid && di_ready;
  // an empty non-final word is swallowed without touching the block
  assign w_wr    = w_acc && (di_bytes != 3'd0 || di_last);
  assign w_close = w_wr && (di_last || r_idx == IDX_W'(WORDS-1));
  assign w_xfer  = w_held && mo_ready;

  assign w_n   = {1'b0, r_idx, 2'b00} + {3'b000, di_bytes};
  assign w_pad = di_last && (w_n < 6'd32);

  hash_pad_word u_pad_cur (
    .i_word     (di),
    .i_bytes    (w_pad ? di_bytes : 3'd4),
    .i_is_slot7 (w_pad && r_idx == IDX_W'(WORDS-1)),
    .i_pad_len  ({2'b00, w_n}),
    .o_word     (w_word)
  );

  hash_pad_word u_pad_tail (
    .i_word     ('0),
    .i_bytes    (3'd0),
    .i_is_slot7 (1'b1),
    .i_pad_len  ({2'b00, w_n}),
    .o_word     (w_tail)
  );

  always_comb begin
    w_next = r_fill;
    for (int s = 0; s < WORDS; s++) begin
      if (s == int'(r_idx))
        w_next[slot_hi(s) -: WORD_W] = w_word;
      else if (w_pad && s > int'(r_idx))
        w_next[slot_hi(s) -: WORD_W] = (s == WORDS-1) ? w_tail : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FILL;
      r_idx     <= '0;
      r_fill    <= '0;
      r_mo      <= '0;
      r_mo_last <= 1'b0;
      r_mo_pad  <= 1'b0;
`ifdef HASH_LOADER_SKID_EN
      r_fc      <= 1'b0;
      r_fl      <= 1'b0;
      r_fp      <= 1'b0;
`endif
    end else begin
      if (w_wr) begin
        r_fill <= w_next;
        r_idx  <= r_idx + 1'b1;
      end
      if (w_close)
        r_idx <= '0;
      if (w_close && (!w_held || w_xfer)) begin
        r_mo      <= w_next;
        r_mo_last <= di_last;
        r_mo_pad  <= w_pad;
        r_state   <= HOLD;
      end
`ifdef HASH_LOADER_SKID_EN
      else if (w_close) begin
        r_fc <= 1'b1;
        r_fl <= di_last;
        r_fp <= w_pad;
      end
      else if (w_xfer && r_fc) begin
        r_mo      <= r_fill;
        r_mo_last <= r_fl;
        r_mo_pad  <= r_fp;
        r_fc      <= 1'b0;
      end
`endif
      else if (w_xfer)
        r_state <= FILL;
    end
  end

  assign mo        = r_mo;
  assign mo_valid  = w_held;
  assign mo_last   = r_mo_last;
  assign mo_padded = r_mo_pad;

endmodule
